// File: rtl/spi_pkg.sv
// spi_pkg: SPI mode encodings, CPOL/CPHA decode and slave state type
package spi_pkg;
    localparam logic [1:0] SPI_MODE0 = 2'd0;
    localparam logic [1:0] SPI_MODE1 = 2'd1;
    localparam logic [1:0] SPI_MODE2 = 2'd2;
    localparam logic [1:0] SPI_MODE3 = 2'd3;
    typedef enum logic {IDLE, ACTIVE} state_t;
    function automatic logic spi_cpol(input logic [1:0] mode);
        return mode[1];
    endfunction
    function automatic logic spi_cpha(input logic [1:0] mode);
        return mode[0];
    endfunction
endpackage

// File: rtl/spi_slave_multimode_if.sv
// spi_slave_multimode_if: TX push handshake and RX/status outputs of the SPI slave
interface spi_slave_multimode_if #(parameter int DATA_WIDTH = 8);
    logic i_tx_valid, o_tx_ready, o_rx_valid, o_tx_underrun, o_frame_abort, o_busy;
    logic [DATA_WIDTH-1:0] i_tx_data, o_rx_data;
    modport master (
        output i_tx_valid, i_tx_data,
        input  o_tx_ready, o_rx_valid, o_rx_data, o_tx_underrun, o_frame_abort, o_busy
    );
    modport slave (
        input  i_tx_valid, i_tx_data,
        output o_tx_ready, o_rx_valid, o_rx_data, o_tx_underrun, o_frame_abort, o_busy
    );
endinterface

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: synchronous FIFO with ready/valid push, pop strobe and empty flag
module spi_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_sys_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic push, pop;
    assign push = i_valid && o_ready;
    assign pop = i_pop && !o_empty;
    assign o_ready = count != CW'(DEPTH);
    assign o_empty = count == '0;
    assign o_data = mem[rd_ptr];
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge i_sys_clk) if (push) mem[wr_ptr] <= i_data;
endmodule

// File: rtl/spi_slave_multimode.sv
// spi_slave_multimode: oversampled SPI slave, all four modes, configurable width/order, TX FIFO
module spi_slave_multimode
    import spi_pkg::*;
#(
    parameter int SPI_MODE = 0,
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST = 1,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic i_sys_clk,
    input  logic i_rst,
    spi_slave_multimode_if.slave bus,
    input  logic i_spi_sck,
    input  logic i_spi_mosi,
    input  logic i_spi_cs_b,
    output logic o_spi_miso
);
    localparam logic CPOL = spi_cpol(2'(SPI_MODE));
    localparam logic CPHA = spi_cpha(2'(SPI_MODE));
    localparam int CW = $clog2(DATA_WIDTH + 1);
    function automatic logic [DATA_WIDTH-1:0] orient(input logic [DATA_WIDTH-1:0] w);
        for (int i = 0; i < DATA_WIDTH; i++) orient[i] = (MSB_FIRST != 0) ? w[i] : w[DATA_WIDTH-1-i];
    endfunction
    state_t state, next_state;
    logic sck_s1, sck_s2, sck_d, mosi_s1, mosi_s2, mosi_d, cs_s1, cs_s2, cs_d;
    logic lead_e, trail_e, cs_fall, cs_rise;
    logic start, stop, smp, shf, last, load, fifo_empty;
    logic [CW-1:0] cnt;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_next, ld_word, fifo_data;
    // Synchronisers are left unreset so a CS already low at reset release gives no edge
    always_ff @(posedge i_sys_clk) begin
        {sck_d, sck_s2, sck_s1} <= {sck_s2, sck_s1, i_spi_sck};
        {mosi_d, mosi_s2, mosi_s1} <= {mosi_s2, mosi_s1, i_spi_mosi};
        {cs_d, cs_s2, cs_s1} <= {cs_s2, cs_s1, i_spi_cs_b};
    end
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            lead_e <= 1'b0;
            trail_e <= 1'b0;
            cs_fall <= 1'b0;
            cs_rise <= 1'b0;
        end else begin
            lead_e <= CPOL ? (sck_d & ~sck_s2) : (sck_s2 & ~sck_d);
            trail_e <= CPOL ? (sck_s2 & ~sck_d) : (sck_d & ~sck_s2);
            cs_fall <= cs_d & ~cs_s2;
            cs_rise <= cs_s2 & ~cs_d;
        end
    end
    always_ff @(posedge i_sys_clk) state <= i_rst ? IDLE : next_state;
    always_comb begin
        start = state == IDLE && cs_fall;
        stop = state == ACTIVE && cs_rise;
        next_state = start ? ACTIVE : stop ? IDLE : state;
        smp = state == ACTIVE && !cs_rise && (CPHA ? trail_e : lead_e);
        shf = state == ACTIVE && !cs_rise && (CPHA ? lead_e : trail_e);
        last = smp && cnt == CW'(DATA_WIDTH - 1);
        load = start || last;
        ld_word = fifo_empty ? '0 : orient(fifo_data);
        rx_next = (MSB_FIRST != 0) ? {rx_sr[DATA_WIDTH-2:0], mosi_d} : {mosi_d, rx_sr[DATA_WIDTH-1:1]};
    end
    spi_tx_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_FIFO_DEPTH)) u_fifo (
        .i_sys_clk(i_sys_clk),
        .i_rst(i_rst),
        .i_valid(bus.i_tx_valid),
        .i_data(bus.i_tx_data),
        .o_ready(bus.o_tx_ready),
        .i_pop(load),
        .o_data(fifo_data),
        .o_empty(fifo_empty)
    );
    assign bus.o_busy = state == ACTIVE;
    // Shift register always emits its MSB; LSB-first words are bit-reversed on load
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            cnt <= '0;
            tx_sr <= '0;
            rx_sr <= '0;
            o_spi_miso <= 1'b0;
            bus.o_rx_data <= '0;
            bus.o_rx_valid <= 1'b0;
            bus.o_tx_underrun <= 1'b0;
            bus.o_frame_abort <= 1'b0;
        end else begin
            bus.o_rx_valid <= last;
            bus.o_tx_underrun <= load && fifo_empty;
            bus.o_frame_abort <= stop && cnt != '0;
            if (start || stop || last) cnt <= '0;
            else if (smp) cnt <= cnt + CW'(1);
            if (smp) rx_sr <= rx_next;
            if (last) bus.o_rx_data <= rx_next;
            if (start && !CPHA) o_spi_miso <= ld_word[DATA_WIDTH-1];
            else if (shf) o_spi_miso <= tx_sr[DATA_WIDTH-1];
            if (load) tx_sr <= (start && !CPHA) ? ld_word << 1 : ld_word;
            else if (shf) tx_sr <= tx_sr << 1;
        end
    end
endmodule

// File: tb/tb_spi_slave_multimode.sv
// tb_spi_slave_multimode: scoreboard bench over five mode/width/bit-order configurations
module tb_spi_slave_multimode;
    typedef struct {int dut; int kind; logic [31:0] data;} ev_t;
    localparam int RX = 0, UR = 1, AB = 2;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] sck, mosi, cs, tv, miso, tr, rv, ur, ab, bz;
    logic [31:0] td [5];
    logic [4:0][31:0] rdat;
    ev_t q[$];
    ev_t e;
    int errors = 0, checks = 0;
    logic [31:0] r0, r1;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 5; g++) begin : u
        localparam int W = (g >= 1 && g <= 3) ? 16 : 8;
        spi_slave_multimode_if #(.DATA_WIDTH(W)) intf ();
        spi_slave_multimode #(
            .SPI_MODE(g == 4 ? 0 : g), .DATA_WIDTH(W), .MSB_FIRST(g == 4 ? 0 : 1), .TX_FIFO_DEPTH(4)
        ) dut (
            .i_sys_clk(clk),
            .i_rst(rst),
            .bus(intf),
            .i_spi_sck(sck[g]),
            .i_spi_mosi(mosi[g]),
            .i_spi_cs_b(cs[g]),
            .o_spi_miso(miso[g])
        );
        assign intf.i_tx_valid = tv[g];
        assign intf.i_tx_data = td[g][W-1:0];
        assign tr[g] = intf.o_tx_ready;
        assign rv[g] = intf.o_rx_valid;
        assign ur[g] = intf.o_tx_underrun;
        assign ab[g] = intf.o_frame_abort;
        assign bz[g] = intf.o_busy;
        assign rdat[g] = 32'(intf.o_rx_data);
    end
    function automatic int mode_of(input int k);
        return k == 4 ? 0 : k;
    endfunction
    function automatic int width_of(input int k);
        return (k >= 1 && k <= 3) ? 16 : 8;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic expect_ev(input int k, input int t, input logic [31:0] d);
        q.push_back('{k, t, d});
    endtask
    task automatic push(input int k, input logic [31:0] d);
        int n = 0;
        while (!tr[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tr[k]) begin
            checks++;
            errors++;
            $display("FAIL push dut%0d: tx_ready stuck at 0, expected 1", k);
        end
        tv[k] = 1'b1;
        td[k] = d;
        @(negedge clk);
        tv[k] = 1'b0;
    endtask
    task automatic xfer(input int k, input int n, input logic [31:0] w0, input logic [31:0] w1,
                        output logic [31:0] o0, output logic [31:0] o1);
        int wd = width_of(k);
        bit cpol = 1'(mode_of(k) / 2);
        bit cpha = 1'(mode_of(k) % 2);
        bit msb = k != 4;
        logic [31:0] w [2];
        logic [31:0] r [2];
        w[0] = w0;
        w[1] = w1;
        r[0] = '0;
        r[1] = '0;
        cs[k] = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            int j, p;
            j = i / wd;
            p = msb ? wd - 1 - i % wd : i % wd;
            if (!cpha) mosi[k] = w[j][p];
            repeat (8) @(negedge clk);
            sck[k] = ~cpol;
            if (!cpha) r[j][p] = miso[k];
            else mosi[k] = w[j][p];
            repeat (8) @(negedge clk);
            sck[k] = cpol;
            if (cpha) r[j][p] = miso[k];
        end
        repeat (8) @(negedge clk);
        cs[k] = 1'b1;
        repeat (12) @(negedge clk);
        o0 = r[0];
        o1 = r[1];
    endtask
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++)
            for (int t = 0; t < 3; t++)
                if ((t == RX && rv[k]) || (t == UR && ur[k]) || (t == AB && ab[k])) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL event dut%0d kind%0d: got unexpected pulse, expected none", k, t);
                    end else begin
                        e = q.pop_front();
                        if (e.dut != k || e.kind != t || (t == RX && rdat[k] !== e.data)) begin
                            errors++;
                            $display("FAIL event: got dut%0d kind%0d data %h, expected dut%0d kind%0d data %h",
                                     k, t, rdat[k], e.dut, e.kind, e.data);
                        end
                    end
                end
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end
    initial begin
        rst = 1'b1;
        tv = '0;
        mosi = '0;
        cs = '1;
        for (int k = 0; k < 5; k++) begin
            sck[k] = 1'(mode_of(k) / 2);
            td[k] = '0;
        end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset rx_valid", 32'(rv[0]), 0);
        chk("reset rx_data", rdat[0], 0);
        chk("reset underrun", 32'(ur[0]), 0);
        chk("reset abort", 32'(ab[0]), 0);
        chk("reset busy", 32'(bz[0]), 0);
        chk("reset miso", 32'(miso[0]), 0);
        chk("reset tx_ready", 32'(tr[0]), 1);
        push(0, 'hA5);
        expect_ev(0, RX, 'h3C);
        expect_ev(0, UR, 0);
        xfer(0, 8, 'h3C, 0, r0, r1);
        chk("mode0 miso", r0, 'hA5);
        for (int k = 1; k <= 3; k++) begin
            push(k, 'h1234);
            push(k, 'hBEEF);
            expect_ev(k, RX, 'hCAFE);
            expect_ev(k, RX, 'h0F0F);
            expect_ev(k, UR, 0);
            xfer(k, 32, 'hCAFE, 'h0F0F, r0, r1);
            chk($sformatf("mode%0d miso word0", k), r0, 'h1234);
            chk($sformatf("mode%0d miso word1", k), r1, 'hBEEF);
        end
        push(4, 'h80);
        expect_ev(4, RX, 'h01);
        expect_ev(4, UR, 0);
        xfer(4, 8, 'h01, 0, r0, r1);
        chk("lsb-first miso", r0, 'h80);
        expect_ev(0, UR, 0);
        expect_ev(0, RX, 'h5A);
        expect_ev(0, UR, 0);
        xfer(0, 8, 'h5A, 0, r0, r1);
        chk("underrun miso zeros", r0, 0);
        push(0, 'h11);
        push(0, 'h22);
        push(0, 'h33);
        chk("ready with 3 queued", 32'(tr[0]), 1);
        push(0, 'h44);
        chk("ready when full", 32'(tr[0]), 0);
        expect_ev(0, RX, 'h96);
        xfer(0, 8, 'h96, 0, r0, r1);
        chk("full fifo head miso", r0, 'h11);
        chk("ready after pop", 32'(tr[0]), 1);
        expect_ev(0, AB, 0);
        xfer(0, 5, 'hFF, 0, r0, r1);
        push(0, 'h55);
        cs[0] = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mosi[0] = 1'b1;
            repeat (8) @(negedge clk);
            sck[0] = 1'b1;
            repeat (8) @(negedge clk);
            sck[0] = 1'b0;
        end
        repeat (8) @(negedge clk);
        chk("busy mid-frame", 32'(bz[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid-reset rx_valid", 32'(rv[0]), 0);
        chk("mid-reset rx_data", rdat[0], 0);
        chk("mid-reset underrun", 32'(ur[0]), 0);
        chk("mid-reset abort", 32'(ab[0]), 0);
        chk("mid-reset busy", 32'(bz[0]), 0);
        chk("mid-reset miso", 32'(miso[0]), 0);
        chk("mid-reset tx_ready", 32'(tr[0]), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("no frame while cs held low", 32'(bz[0]), 0);
        cs[0] = 1'b1;
        repeat (10) @(negedge clk);
        expect_ev(0, UR, 0);
        expect_ev(0, RX, 'hC3);
        expect_ev(0, UR, 0);
        xfer(0, 8, 'hC3, 0, r0, r1);
        chk("fifo flushed by reset", r0, 0);
        repeat (10) @(negedge clk);
        chk("pending events", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
